// File: rtl/conv_frame_ctrl_pkg.sv
// Shared types for the 3x3 convolution pipeline:
// sequencer states, kernel modes and default frame geometry.
package conv_pkg;

   localparam int IMG_W_DEF  = 1280;
   localparam int IMG_H_DEF  = 960;
   localparam int LAT_DEF    = 3;
   localparam int BORDER_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      GRAY      = 2'd0,
      SOBEL_V   = 2'd1,
      SOBEL_H   = 2'd2,
      SOBEL_MAG = 2'd3
   } kmode_e;

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Pixel stream, mode handshake and status signals of the
// convolution frame sequencer.
interface conv_frame_ctrl_if;

   logic        iDVAL;
   logic [10:0] iX_Cont;
   logic [10:0] iY_Cont;
   logic [1:0]  iMODE;
   logic        iMODE_REQ;
   logic [1:0]  oMODE;
   logic        oMODE_ACK;
   logic        oDVAL;
   logic        oZERO;
   logic        oFRAME_DONE;
   logic [1:0]  oSTATE;

   modport master (
      output iDVAL, iX_Cont, iY_Cont, iMODE, iMODE_REQ,
      input  oMODE, oMODE_ACK, oDVAL, oZERO, oFRAME_DONE, oSTATE
   );

   modport slave (
      input  iDVAL, iX_Cont, iY_Cont, iMODE, iMODE_REQ,
      output oMODE, oMODE_ACK, oDVAL, oZERO, oFRAME_DONE, oSTATE
   );

endinterface

// File: rtl/conv_frame_ctrl_delay_line.sv
// LAT-deep, N-bit shift register with synchronous reset;
// realigns control strobes with the datapath result.
module conv_delay_line #(
   parameter int LAT = 3,
   parameter int N   = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] sr_q [LAT];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[LAT-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution: pixel position,
// border mask, frame-aligned kernel mode and latency-matched strobes.
module conv_frame_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int LAT    = LAT_DEF,
   parameter int BORDER = BORDER_DEF
) (
   input logic iCLK,
   input logic iRST,
   conv_frame_ctrl_if.slave bus
);

   localparam logic [10:0] W_LAST = 11'(IMG_W - 1);
   localparam logic [10:0] H_LAST = 11'(IMG_H - 1);
   localparam logic [10:0] B_LO   = 11'(BORDER);
   localparam logic [10:0] W_HI   = 11'(IMG_W - BORDER);
   localparam logic [10:0] H_HI   = 11'(IMG_H - BORDER);

   state_e      state_q, state_d;
   logic [10:0] col_q, col_d;
   logic [10:0] row_q, row_d;
   kmode_e      mode_q, mode_d;
   kmode_e      pmode_q, pmode_d;
   logic        pend_q, pend_d;
   logic        ack_q, ack_d;
   logic        done_q, done_d;

   logic        fs;
   logic        eol;
   logic        z;
   logic [10:0] col_p;
   logic [10:0] row_p;
   logic [1:0]  dly_in;
   logic [1:0]  dly_out;

   // Position of the pixel being sampled; an FS pixel is (0,0).
   assign fs    = bus.iDVAL && bus.iX_Cont == '0 && bus.iY_Cont == '0;
   assign col_p = fs ? '0 : col_q;
   assign row_p = fs ? '0 : row_q;
   assign eol   = col_p == W_LAST;

   assign z = (state_q == IDLE) || (row_p < 11'd2) || (col_p < 11'd2) ||
              (col_p < B_LO) || (col_p >= W_HI) ||
              (row_p < B_LO) || (row_p >= H_HI);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      mode_d  = mode_q;
      pmode_d = pmode_q;
      pend_d  = pend_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;

      if (bus.iDVAL) begin
         col_d = eol ? '0 : col_p + 11'd1;
         row_d = eol ? row_p + 11'd1 : row_p;
      end

      if (fs) begin
         state_d = PRIME;
      end else if (bus.iDVAL) begin
         unique case (state_q)
            IDLE:  state_d = IDLE;
            PRIME: if (eol && row_p == 11'd1) state_d = RUN;
            RUN: begin
               if (eol && row_p == H_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Mode switches only at frame start so a frame never mixes kernels.
      if (fs) begin
         if (bus.iMODE_REQ) begin
            mode_d = kmode_e'(bus.iMODE);
            ack_d  = 1'b1;
            pend_d = 1'b0;
         end else if (pend_q) begin
            mode_d = pmode_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
         end
      end else if (bus.iMODE_REQ) begin
         pmode_d = kmode_e'(bus.iMODE);
         pend_d  = 1'b1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         mode_q  <= GRAY;
         pmode_q <= GRAY;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         mode_q  <= mode_d;
         pmode_q <= pmode_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign dly_in = {bus.iDVAL, bus.iDVAL & z};

   conv_delay_line #(
      .LAT (LAT),
      .N   (2)
   ) u_dly (
      .clk_i (iCLK),
      .rst_i (iRST),
      .d_i   (dly_in),
      .q_o   (dly_out)
   );

   assign bus.oDVAL       = dly_out[1];
   assign bus.oZERO       = dly_out[0];
   assign bus.oMODE       = mode_q;
   assign bus.oMODE_ACK   = ack_q;
   assign bus.oFRAME_DONE = done_q;
   assign bus.oSTATE      = state_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl on an 8x6 frame,
// LAT=3, BORDER=2.
module tb_conv_frame_ctrl;

   localparam int W   = 8;
   localparam int H   = 6;
   localparam int LAT = 3;

   typedef struct {
      int   cyc;
      logic z;
   } exp_t;

   logic iCLK = 1'b0;
   logic iRST = 1'b1;

   conv_frame_ctrl_if bus ();

   conv_frame_ctrl #(
      .IMG_W  (W),
      .IMG_H  (H),
      .LAT    (LAT),
      .BORDER (2)
   ) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   always #5 iCLK = ~iCLK;

   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   exp_t sb[$];
   logic mon_en = 1'b0;
   int   nz_cnt, done_cnt, done_cyc, ack_cnt, ack_cyc;
   int   chg_cnt, chg_cyc;
   logic [1:0] prev_mode = 2'd0;
   int   fs_cyc, last_cyc;

   always @(posedge iCLK) cyc++;

   // Output monitor: pops expected pixels and logs pulse events.
   always @(negedge iCLK) begin
      if (mon_en) begin
         if (bus.oDVAL) begin
            total++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected cyc=%0d oDVAL=1 with no pixel in flight",
                        cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (cyc !== e.cyc || bus.oZERO !== e.z)
                  $display("FAIL sb_pixel got cyc=%0d z=%0b want cyc=%0d z=%0b",
                           cyc, bus.oZERO, e.cyc, e.z);
               else passed++;
               if (bus.oZERO === 1'b0) nz_cnt++;
            end
         end else begin
            total++;
            if (bus.oZERO !== 1'b0)
               $display("FAIL zero_no_dval cyc=%0d oZERO=%0b want 0",
                        cyc, bus.oZERO);
            else passed++;
         end
         if (bus.oFRAME_DONE === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.oMODE_ACK === 1'b1) begin
            ack_cnt++;
            ack_cyc = cyc;
         end
         if (bus.oMODE !== prev_mode) begin
            chg_cnt++;
            chg_cyc = cyc;
         end
      end
      prev_mode = bus.oMODE;
   end

   function automatic logic zexp(input int r, input int c);
      return !(r >= 2 && r <= H - 3 && c >= 2 && c <= W - 3);
   endfunction

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic clr_stats();
      nz_cnt = 0; done_cnt = 0; done_cyc = -1;
      ack_cnt = 0; ack_cyc = -1; chg_cnt = 0; chg_cyc = -1;
   endtask

   task automatic frame(input int gap, input int first, input int n,
                        input int req_idx, input logic [1:0] req_mode);
      for (int i = first; i < first + n; i++) begin
         int r, c;
         r = i / W;
         c = i % W;
         step();
         bus.iDVAL     = 1'b1;
         bus.iX_Cont   = 11'(c);
         bus.iY_Cont   = 11'(r);
         bus.iMODE_REQ = (i == req_idx);
         bus.iMODE     = req_mode;
         if (i == 0) fs_cyc = cyc;
         last_cyc = cyc;
         sb.push_back('{cyc + LAT, zexp(r, c)});
         for (int g = 0; g < gap; g++) begin
            step();
            bus.iDVAL     = 1'b0;
            bus.iMODE_REQ = 1'b0;
         end
      end
      step();
      bus.iDVAL     = 1'b0;
      bus.iMODE_REQ = 1'b0;
   endtask

   task automatic drain();
      repeat (LAT + 4) step();
   endtask

   task automatic test_reset();
      bus.iDVAL = 1'b0; bus.iX_Cont = '0; bus.iY_Cont = '0;
      bus.iMODE = 2'd0; bus.iMODE_REQ = 1'b0;
      iRST = 1'b1;
      step(); step();
      iRST = 1'b0;
      total++;
      if ({bus.oDVAL, bus.oZERO, bus.oMODE_ACK, bus.oFRAME_DONE} !== 4'b0 ||
          bus.oMODE !== 2'd0 || bus.oSTATE !== 2'd0)
         $display("FAIL reset_outs got dval=%0b z=%0b ack=%0b done=%0b mode=%0d st=%0d want all 0",
                  bus.oDVAL, bus.oZERO, bus.oMODE_ACK, bus.oFRAME_DONE,
                  bus.oMODE, bus.oSTATE);
      else passed++;
      mon_en = 1'b1;
   endtask

   task automatic check_frame(input string nm, input int nz_want,
                              input int done_want);
      total++;
      if (sb.size() != 0)
         $display("FAIL %s_drained got %0d left want 0", nm, sb.size());
      else passed++;
      total++;
      if (nz_cnt != nz_want)
         $display("FAIL %s_nz got %0d want %0d", nm, nz_cnt, nz_want);
      else passed++;
      total++;
      if (done_cnt != done_want || (done_want == 1 && done_cyc != last_cyc + 1))
         $display("FAIL %s_done got n=%0d cyc=%0d want n=%0d cyc=%0d",
                  nm, done_cnt, done_cyc, done_want, last_cyc + 1);
      else passed++;
      total++;
      if (bus.oSTATE !== 2'd0)
         $display("FAIL %s_state got %0d want 0", nm, bus.oSTATE);
      else passed++;
   endtask

   task automatic test_full_frame();
      clr_stats();
      frame(0, 0, W * H, -1, 2'd0);
      drain();
      check_frame("full", 8, 1);
   endtask

   task automatic test_gap_frame();
      clr_stats();
      frame(1, 0, W * H, -1, 2'd0);
      drain();
      check_frame("gap", 8, 1);
   endtask

   task automatic test_mode_defer();
      clr_stats();
      frame(0, 0, W * H, 20, 2'd2);
      step();
      bus.iMODE = 2'd1; bus.iMODE_REQ = 1'b1;
      step();
      bus.iMODE_REQ = 1'b0;
      total++;
      if (bus.oMODE !== 2'd0 || chg_cnt != 0)
         $display("FAIL defer_hold got mode=%0d chg=%0d want 0/0",
                  bus.oMODE, chg_cnt);
      else passed++;
      frame(0, 0, W * H, -1, 2'd0);
      drain();
      total++;
      if (bus.oMODE !== 2'd1 || chg_cnt != 1 || chg_cyc != fs_cyc + 1)
         $display("FAIL defer_mode got mode=%0d chg=%0d at %0d want 1/1 at %0d",
                  bus.oMODE, chg_cnt, chg_cyc, fs_cyc + 1);
      else passed++;
      total++;
      if (ack_cnt != 1 || ack_cyc != fs_cyc + 1)
         $display("FAIL defer_ack got n=%0d at %0d want 1 at %0d",
                  ack_cnt, ack_cyc, fs_cyc + 1);
      else passed++;
      check_frame("defer", 16, 2);
   endtask

   task automatic test_mode_at_fs();
      clr_stats();
      frame(0, 0, W * H, 0, 2'd3);
      drain();
      total++;
      if (bus.oMODE !== 2'd3 || chg_cyc != fs_cyc + 1)
         $display("FAIL fsreq_mode got mode=%0d at %0d want 3 at %0d",
                  bus.oMODE, chg_cyc, fs_cyc + 1);
      else passed++;
      total++;
      if (ack_cnt != 1 || ack_cyc != fs_cyc + 1)
         $display("FAIL fsreq_ack got n=%0d at %0d want 1 at %0d",
                  ack_cnt, ack_cyc, fs_cyc + 1);
      else passed++;
   endtask

   task automatic test_abort();
      clr_stats();
      frame(0, 0, 28, -1, 2'd0);
      total++;
      if (bus.oSTATE !== 2'd2)
         $display("FAIL abort_run got %0d want 2", bus.oSTATE);
      else passed++;
      frame(0, 0, 1, -1, 2'd0);
      total++;
      if (bus.oSTATE !== 2'd1)
         $display("FAIL abort_prime got %0d want 1", bus.oSTATE);
      else passed++;
      frame(0, 1, W * H - 1, -1, 2'd0);
      drain();
      check_frame("abort", 14, 1);
   endtask

   task automatic test_reset_mid();
      int rc;
      clr_stats();
      frame(0, 0, 20, 5, 2'd2);
      step();
      bus.iDVAL = 1'b1; bus.iX_Cont = 11'd4; bus.iY_Cont = 11'd2;
      iRST = 1'b1;
      rc = cyc;
      while (sb.size() != 0 && sb[sb.size()-1].cyc > rc) sb.pop_back();
      step();
      iRST = 1'b0;
      bus.iDVAL = 1'b0;
      total++;
      if ({bus.oDVAL, bus.oZERO, bus.oMODE_ACK, bus.oFRAME_DONE} !== 4'b0 ||
          bus.oMODE !== 2'd0 || bus.oSTATE !== 2'd0)
         $display("FAIL rstmid_outs got dval=%0b z=%0b ack=%0b done=%0b mode=%0d st=%0d want all 0",
                  bus.oDVAL, bus.oZERO, bus.oMODE_ACK, bus.oFRAME_DONE,
                  bus.oMODE, bus.oSTATE);
      else passed++;
      drain();
      clr_stats();
      frame(0, 0, W * H, -1, 2'd0);
      drain();
      total++;
      if (ack_cnt != 0 || bus.oMODE !== 2'd0)
         $display("FAIL rstmid_pending got ack=%0d mode=%0d want 0/0",
                  ack_cnt, bus.oMODE);
      else passed++;
      check_frame("rstmid", 8, 1);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_gap_frame();
      test_mode_defer();
      test_mode_at_fs();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
